// File: rtl/fog_lut_loader_pkg.sv
// Shared constants, load-FSM state type and the fog interpolate/clamp helper
// used by the fog LUT loader.
package fog_lut_loader_pkg;

  localparam int FOG_LUT_WORDS   = 66;
  localparam int FOG_BOUND_WORDS = 2;
  localparam int FOG_FIELD_W     = 16;
  localparam int FOG_SLOPE_LSB   = 16;
  localparam int FOG_OFFSET_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SWAP = 2'd2
  } load_state_e;

  // offset(u8.8) + (slope(s8.8) * frac(u0.16)) >>> 16, clamped to 0..255 of the integer part
  function automatic logic [7:0] fog_interp(input logic [15:0] slope,
                                            input logic [15:0] offset,
                                            input logic [15:0] frac);
    logic signed [32:0] prod;
    logic signed [32:0] sum;
    prod = $signed({{17{slope[15]}}, slope}) * $signed({17'd0, frac});
    sum  = $signed({17'd0, offset}) + (prod >>> 16);
    if (sum < 33'sd0) begin
      fog_interp = 8'd0;
    end else if (sum >= 33'sh0FF00) begin
      fog_interp = 8'hFF;
    end else begin
      fog_interp = sum[15:8];
    end
  endfunction

endpackage

// File: rtl/fog_lut_loader_if.sv
// AXI-stream style fog-LUT upload channel from the command parser.
interface fog_lut_loader_if #(
  parameter int CMD_STREAM_WIDTH = 32
);
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;
  logic [CMD_STREAM_WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/fog_lut_bank_ram.sv
// Two-bank LUT storage: one write port for the shadow bank, one registered
// read port for the active bank. No reset so it maps onto block RAM.
module fog_lut_bank_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

  // Shadow-bank write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered active-bank read port
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fog_lut_loader.sv
// Fog LUT loader: double-buffered upload of bounds and 64 slope/offset entries
// with an atomic bank swap, plus a 2-stage stallable interpolate/clamp lookup.
module fog_lut_loader
  import fog_lut_loader_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 32,
  parameter int LUT_DEPTH_LOG2   = 6
) (
  input  logic                      aclk,
  input  logic                      reset,
  fog_lut_loader_if.slave           s_fog_axis,
  output logic [31:0]               lower_bound,
  output logic [31:0]               upper_bound,
  output logic                      lut_valid,
  output logic                      upload_error,
  input  logic                      lookup_valid,
  input  logic [LUT_DEPTH_LOG2-1:0] lookup_index,
  input  logic [15:0]               lookup_frac,
  input  logic                      lookup_stall,
  output logic                      fog_valid,
  output logic [7:0]                fog_intensity
);

  localparam int CNT_W     = LUT_DEPTH_LOG2 + 1;
  localparam int LAST_WORD = FOG_BOUND_WORDS + (1 << LUT_DEPTH_LOG2) - 1;

  load_state_e                 state_r, state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_s;
  logic                        ready_r, beat_s, err_s, swap_s;
  logic                        wr_en_s, lower_we_s, upper_we_s;
  logic [LUT_DEPTH_LOG2-1:0]   wr_idx_s;
  logic [CMD_STREAM_WIDTH-1:0] beat_data_s;
  logic [31:0]                 shadow_lower_r, shadow_upper_r, entry_s;
  logic                        active_bank_r, s1_valid_r;
  logic [15:0]                 s1_frac_r;

  assign s_fog_axis.tready = ready_r;
  assign beat_s            = s_fog_axis.tvalid & ready_r;
  assign beat_data_s       = s_fog_axis.tdata;
  assign wr_idx_s          = cnt_r[LUT_DEPTH_LOG2-1:0] - LUT_DEPTH_LOG2'(2);

  // Load FSM next-state, counter and write-enable decode
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    err_s      = 1'b0;
    swap_s     = 1'b0;
    wr_en_s    = 1'b0;
    lower_we_s = 1'b0;
    upper_we_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_LOAD: begin
        if (beat_s) begin
          lower_we_s = (cnt_r == CNT_W'(0));
          upper_we_s = (cnt_r == CNT_W'(1));
          wr_en_s    = (cnt_r >= CNT_W'(FOG_BOUND_WORDS));
          if (cnt_r == CNT_W'(LAST_WORD)) begin
            state_s = ST_SWAP;
            err_s   = ~s_fog_axis.tlast;
          end else if (s_fog_axis.tlast) begin
            // short upload: drop the shadow contents and start over
            state_s = ST_IDLE;
            cnt_s   = {CNT_W{1'b0}};
            err_s   = 1'b1;
          end else begin
            state_s = ST_LOAD;
            cnt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_SWAP: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        swap_s  = 1'b1;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state, word counter, registered tready and error pulse
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      ready_r      <= 1'b0;
      upload_error <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      ready_r      <= (state_s != ST_SWAP);
      upload_error <= err_s;
    end
  end

  // Shadow bound registers filled by the first two beats
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      shadow_lower_r <= 32'd0;
      shadow_upper_r <= 32'd0;
    end else begin
      if (lower_we_s) shadow_lower_r <= beat_data_s[31:0];
      if (upper_we_s) shadow_upper_r <= beat_data_s[31:0];
    end
  end

  // Atomic swap: bank select and published bounds change together
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      active_bank_r <= 1'b0;
      lut_valid     <= 1'b0;
      lower_bound   <= 32'd0;
      upper_bound   <= 32'd0;
    end else if (swap_s) begin
      active_bank_r <= ~active_bank_r;
      lut_valid     <= 1'b1;
      lower_bound   <= shadow_lower_r;
      upper_bound   <= shadow_upper_r;
    end
  end

  fog_lut_bank_ram #(
    .ADDR_W (LUT_DEPTH_LOG2 + 1),
    .DATA_W (32)
  ) u_bank_ram (
    .clk     (aclk),
    .wr_en   (wr_en_s),
    .wr_addr ({~active_bank_r, wr_idx_s}),
    .wr_data (beat_data_s[31:0]),
    .rd_en   (~lookup_stall),
    .rd_addr ({active_bank_r, lookup_index}),
    .rd_data (entry_s)
  );

  // Lookup pipeline: S1 alongside the RAM read, S2 interpolate and clamp
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      s1_valid_r    <= 1'b0;
      s1_frac_r     <= 16'd0;
      fog_valid     <= 1'b0;
      fog_intensity <= 8'd0;
    end else if (!lookup_stall) begin
      s1_valid_r <= lookup_valid;
      s1_frac_r  <= lookup_frac;
      fog_valid  <= s1_valid_r;
      if (s1_valid_r) begin
        fog_intensity <= fog_interp(entry_s[FOG_SLOPE_LSB +: FOG_FIELD_W],
                                    entry_s[FOG_OFFSET_LSB +: FOG_FIELD_W], s1_frac_r);
      end
    end
  end

endmodule

// File: tb/tb_fog_lut_loader.sv
// Self-checking bench for fog_lut_loader: uploads, swaps, aborts, stalls and
// resets, with lookups scored against an arithmetic fog model.
module tb_fog_lut_loader;

  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] lower_bound, upper_bound;
  logic        lut_valid, upload_error;
  logic        lookup_valid, lookup_stall;
  logic [5:0]  lookup_index;
  logic [15:0] lookup_frac;
  logic        fog_valid;
  logic [7:0]  fog_intensity;

  always #5 aclk = ~aclk;

  fog_lut_loader_if #(.CMD_STREAM_WIDTH(32)) s_fog_axis ();

  fog_lut_loader #(.CMD_STREAM_WIDTH(32), .LUT_DEPTH_LOG2(6)) dut (
    .aclk          (aclk),
    .reset         (reset),
    .s_fog_axis    (s_fog_axis),
    .lower_bound   (lower_bound),
    .upper_bound   (upper_bound),
    .lut_valid     (lut_valid),
    .upload_error  (upload_error),
    .lookup_valid  (lookup_valid),
    .lookup_index  (lookup_index),
    .lookup_frac   (lookup_frac),
    .lookup_stall  (lookup_stall),
    .fog_valid     (fog_valid),
    .fog_intensity (fog_intensity)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] act_tbl [64];
  logic [31:0] act_lo, act_hi;
  logic [31:0] up_words [66];
  bit          m_s1_v, m_out_v;
  int          m_s1_val, m_out_val;

  // Fog factor from the entry rules: offset + floor(slope*frac/2^16), clamped
  function automatic int exp_fog(input logic [31:0] e, input logic [15:0] frac);
    longint sl, off, f, r;
    sl  = {{48{e[31]}}, e[31:16]};
    off = {48'd0, e[15:0]};
    f   = {48'd0, frac};
    r   = off + ((sl * f) >>> 16);
    if (r < 0) return 0;
    else if (r >= 65280) return 255;
    else return int'(r / 256);
  endfunction

  // Drive one lookup cycle and advance the expected 2-deep pipeline
  task automatic lookup_step(input bit v, input logic [5:0] idx, input logic [15:0] frac,
                             input bit stall, input int expv);
    lookup_valid = v; lookup_index = idx; lookup_frac = frac; lookup_stall = stall;
    if (!stall) begin
      m_out_v = m_s1_v; m_out_val = m_s1_val;
      m_s1_v  = v;      m_s1_val  = expv;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input bit gaps);
    int guard;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge aclk);
    s_fog_axis.tvalid = 1'b1; s_fog_axis.tdata = d; s_fog_axis.tlast = last;
    guard = 0;
    while (s_fog_axis.tready !== 1'b1 && guard < 16) begin
      @(negedge aclk); guard++;
    end
    if (guard >= 16) begin
      checks++; errors++;
      $display("FAIL upload_timeout: tready=%b, required 1", s_fog_axis.tready);
    end
    @(negedge aclk);
    s_fog_axis.tvalid = 1'b0; s_fog_axis.tlast = 1'b0;
  endtask

  task automatic send_upload(input int n, input int last_at, input bit gaps);
    for (int i = 0; i < n; i++) send_word(up_words[i], (i == last_at), gaps);
  endtask

  task automatic commit_upload();
    act_lo = up_words[0]; act_hi = up_words[1];
    for (int i = 0; i < 64; i++) act_tbl[i] = up_words[i + 2];
  endtask

  task automatic random_words();
    for (int i = 0; i < 66; i++) up_words[i] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_fog_axis.tvalid = 1'b0; s_fog_axis.tlast = 1'b0; s_fog_axis.tdata = 32'd0;
    lookup_step(1'b0, 6'd0, 16'd0, 1'b0, 0);
    m_s1_v = 1'b0; m_out_v = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if ({s_fog_axis.tready, lut_valid, upload_error, fog_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: tready,lut_valid,err,fog_valid=%b, required 0000",
               {s_fog_axis.tready, lut_valid, upload_error, fog_valid});
    end
    checks++;
    if ({lower_bound, upper_bound, fog_intensity} !== 72'd0) begin
      errors++;
      $display("FAIL reset_data: lo=%h hi=%h fog=%h, required 0", lower_bound, upper_bound,
               fog_intensity);
    end
    reset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_fog_axis.tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready_rise: got %b, required 1", s_fog_axis.tready);
    end
  endtask

  task automatic test_basic_upload();
    up_words[0] = 32'h3F80_0000; up_words[1] = 32'h42C8_0000;
    for (int i = 0; i < 64; i++) up_words[i + 2] = {16'h0000, 16'(i << 8)};
    send_upload(66, 65, 1'b0);
    checks++;
    if ({s_fog_axis.tready, upload_error} !== 2'b00) begin
      errors++; $display("FAIL basic_swap_cycle: tready,err=%b, required 00",
                         {s_fog_axis.tready, upload_error});
    end
    commit_upload();
    @(negedge aclk);
    checks++;
    if ({s_fog_axis.tready, lut_valid, lower_bound, upper_bound} !== {2'b11, act_lo, act_hi}) begin
      errors++; $display("FAIL basic_after_swap: tready=%b lut_valid=%b lo=%h hi=%h, required 1 1 %h %h",
                         s_fog_axis.tready, lut_valid, lower_bound, upper_bound, act_lo, act_hi);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL basic_valid: got %b, required %b", fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL basic_fog: got %0d, required %0d", fog_intensity, m_out_val);
        end
      end
      lookup_step(k == 0, 6'd10, 16'($urandom), 1'b0, 10);
      @(negedge aclk);
    end
  endtask

  task automatic test_interp_clamp();
    random_words();
    up_words[2 + 5] = {16'h0100, 16'h4000};
    up_words[2 + 0] = {16'h7FFF, 16'hFF00};
    up_words[2 + 1] = {16'h8000, 16'h0000};
    send_upload(66, 65, 1'b0);
    commit_upload();
    @(negedge aclk);
    for (int k = 0; k < 40; k++) begin
      logic [5:0]  idx;
      logic [15:0] fr;
      int          ev;
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL interp_valid: got %b, required %b", fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL interp_fog: got %0d, required %0d", fog_intensity, m_out_val);
        end
      end
      idx = 6'($urandom_range(0, 63)); fr = 16'($urandom);
      ev  = exp_fog(act_tbl[idx], fr);
      if (k == 0) begin idx = 6'd5; fr = 16'h8000; ev = 64; end
      if (k == 1) begin idx = 6'd0; fr = 16'hFFFF; ev = 255; end
      if (k == 2) begin idx = 6'd1; fr = 16'hFFFF; ev = 0; end
      lookup_step(k < 37, idx, fr, 1'b0, ev);
      @(negedge aclk);
    end
  endtask

  task automatic test_abort();
    logic [31:0] old_lo;
    old_lo = act_lo;
    random_words();
    send_upload(31, 30, 1'b0);
    checks++;
    if ({upload_error, s_fog_axis.tready, lut_valid} !== 3'b111) begin
      errors++; $display("FAIL abort_pulse: err,tready,lut_valid=%b, required 111",
                         {upload_error, s_fog_axis.tready, lut_valid});
    end
    @(negedge aclk);
    checks++;
    if ({upload_error, lower_bound} !== {1'b0, old_lo}) begin
      errors++; $display("FAIL abort_no_swap: err=%b lo=%h, required 0 %h", upload_error,
                         lower_bound, old_lo);
    end
    for (int k = 0; k < 12; k++) begin
      logic [5:0]  idx;
      logic [15:0] fr;
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL abort_valid: got %b, required %b", fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL abort_old_table: got %0d, required %0d", fog_intensity, m_out_val);
        end
      end
      idx = 6'($urandom_range(0, 63)); fr = 16'($urandom);
      lookup_step(k < 10, idx, fr, 1'b0, exp_fog(act_tbl[idx], fr));
      @(negedge aclk);
    end
    // full length without tlast still swaps but flags an error
    random_words();
    send_upload(66, -1, 1'b0);
    checks++;
    if ({upload_error, s_fog_axis.tready} !== 2'b10) begin
      errors++; $display("FAIL notlast_pulse: err,tready=%b, required 10",
                         {upload_error, s_fog_axis.tready});
    end
    commit_upload();
    @(negedge aclk);
    checks++;
    if ({upload_error, lower_bound, upper_bound} !== {1'b0, act_lo, act_hi}) begin
      errors++; $display("FAIL notlast_swap: err=%b lo=%h hi=%h, required 0 %h %h", upload_error,
                         lower_bound, upper_bound, act_lo, act_hi);
    end
  endtask

  task automatic test_swap_stream();
    random_words();
    for (int c = 0; c < 75; c++) begin
      logic [5:0]  idx;
      logic [15:0] fr;
      logic [31:0] ent;
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL swap_valid: cycle %0d got %b, required %b", c, fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL swap_fog: cycle %0d got %0d, required %0d", c, fog_intensity,
                             m_out_val);
        end
      end
      if (c == 66 || c == 67) begin
        checks++;
        if (s_fog_axis.tready !== (c == 67)) begin
          errors++; $display("FAIL swap_tready: cycle %0d got %b, required %b", c,
                             s_fog_axis.tready, (c == 67));
        end
      end
      s_fog_axis.tvalid = (c < 66);
      s_fog_axis.tlast  = (c == 65);
      s_fog_axis.tdata  = (c < 66) ? up_words[c] : 32'd0;
      idx = 6'($urandom_range(0, 63)); fr = 16'($urandom);
      ent = (c <= 66) ? act_tbl[idx] : up_words[idx + 2];
      lookup_step(c < 72, idx, fr, 1'b0, exp_fog(ent, fr));
      @(negedge aclk);
    end
    commit_upload();
  endtask

  task automatic test_random_stall();
    random_words();
    send_upload(66, 65, 1'b1);
    commit_upload();
    @(negedge aclk);
    checks++;
    if ({lower_bound, upper_bound} !== {act_lo, act_hi}) begin
      errors++; $display("FAIL gaps_bounds: lo=%h hi=%h, required %h %h", lower_bound, upper_bound,
                         act_lo, act_hi);
    end
    for (int k = 0; k < 300; k++) begin
      logic [5:0]  idx;
      logic [15:0] fr;
      bit          st;
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL stall_valid: step %0d got %b, required %b", k, fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL stall_fog: step %0d got %0d, required %0d", k, fog_intensity,
                             m_out_val);
        end
      end
      idx = 6'($urandom_range(0, 63)); fr = 16'($urandom);
      st  = (k < 290) && ($urandom_range(0, 9) < 3);
      lookup_step((k < 290) && ($urandom_range(0, 9) < 7), idx, fr, st, exp_fog(act_tbl[idx], fr));
      @(negedge aclk);
    end
  endtask

  task automatic test_reset_mid_upload();
    random_words();
    send_upload(20, -1, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if ({s_fog_axis.tready, lut_valid, upload_error, fog_valid} !== 4'b0000) begin
      errors++; $display("FAIL midreset_flags: tready,lut_valid,err,fog_valid=%b, required 0000",
                         {s_fog_axis.tready, lut_valid, upload_error, fog_valid});
    end
    checks++;
    if ({lower_bound, upper_bound} !== 64'd0) begin
      errors++; $display("FAIL midreset_bounds: lo=%h hi=%h, required 0", lower_bound, upper_bound);
    end
    m_s1_v = 1'b0; m_out_v = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);
    checks++;
    if (s_fog_axis.tready !== 1'b1) begin
      errors++; $display("FAIL midreset_tready: got %b, required 1", s_fog_axis.tready);
    end
    random_words();
    send_upload(66, 65, 1'b1);
    commit_upload();
    @(negedge aclk);
    checks++;
    if ({lut_valid, lower_bound} !== {1'b1, act_lo}) begin
      errors++; $display("FAIL midreset_reload: lut_valid=%b lo=%h, required 1 %h", lut_valid,
                         lower_bound, act_lo);
    end
    for (int k = 0; k < 20; k++) begin
      logic [5:0]  idx;
      logic [15:0] fr;
      checks++;
      if (fog_valid !== m_out_v) begin
        errors++; $display("FAIL midreset_valid: got %b, required %b", fog_valid, m_out_v);
      end
      if (m_out_v) begin
        checks++;
        if (fog_intensity !== 8'(m_out_val)) begin
          errors++; $display("FAIL midreset_fog: got %0d, required %0d", fog_intensity, m_out_val);
        end
      end
      idx = 6'($urandom_range(0, 63)); fr = 16'($urandom);
      lookup_step(k < 18, idx, fr, 1'b0, exp_fog(act_tbl[idx], fr));
      @(negedge aclk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_upload();
    test_interp_clamp();
    test_abort();
    test_swap_stream();
    test_random_stall();
    test_reset_mid_upload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
